// File: rtl/cpu_traffic_gen.sv
// CPU-side traffic generator and self-checker for the cache_top request/response port.
// Optional response watchdog enabled by defining CPU_TGEN_WATCHDOG_EN.
module cpu_traffic_gen #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_BYTES = 32,
  parameter int unsigned L1_SETS    = 8,
  parameter int unsigned NUM_TAGS   = 4,
  parameter int unsigned NUM_OPS    = 16,
  parameter logic [15:0] PAT_STEP   = 16'h1111,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [7:0]          err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [7:0]          op_count,
  output logic                cpu_req_valid,
  input  logic                cpu_req_ready,
  output logic                cpu_req_rw,
  output logic [ADDR_W-1:0]   cpu_addr,
  output logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W/8-1:0] cpu_wstrb,
  input  logic                cpu_resp_valid,
  input  logic [DATA_W-1:0]   cpu_rdata
);

  localparam int unsigned OFF_W   = $clog2(LINE_BYTES);
  localparam int unsigned TAG_LSB = OFF_W + $clog2(L1_SETS);
  localparam int unsigned TAG_W   = ADDR_W - TAG_LSB;
  localparam int unsigned K_W     = $clog2(NUM_TAGS);
  localparam int unsigned STRB_W  = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [7:0]          op_count_q, op_count_d;
  logic [7:0]          err_count_q, err_count_d;
  logic [ADDR_W-1:0]   first_err_q, first_err_d;
  logic                pass_q, pass_d;
  logic                req_valid_q, req_valid_d;
  logic                req_rw_q, req_rw_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic [STRB_W-1:0]   req_wstrb_q, req_wstrb_d;
  logic [K_W-1:0]      cur_k_q, cur_k_d;
  logic [DATA_W-1:0]   shadow_q [NUM_TAGS];
  logic [DATA_W-1:0]   shadow_d [NUM_TAGS];

  // Request generator: fed from the live inputs when launching a run, else from run state.
  logic                gen_from_in;
  logic [1:0]          gen_mode;
  logic [ADDR_W-1:0]   gen_base;
  logic [7:0]          gen_n;
  logic [15:0]         gen_lfsr;
  logic [K_W-1:0]      gen_k;
  logic                gen_rw;
  logic [DATA_W-1:0]   gen_wdata;
  logic [STRB_W-1:0]   gen_wstrb;
  logic [TAG_W-1:0]    gen_tag;
  logic [ADDR_W-1:0]   gen_addr;
  logic                load_req;

  assign gen_from_in = (state_q == StIdle) || (state_q == StDone);
  assign gen_mode    = gen_from_in ? mode : mode_q;
  assign gen_base    = gen_from_in ? base_addr : base_q;
  assign gen_n       = gen_from_in ? 8'd0 : op_count_q;
  assign gen_lfsr    = gen_from_in ? LFSR_SEED : lfsr_q;

  always_comb begin
    gen_k     = '0;
    gen_rw    = 1'b0;
    gen_wdata = '0;
    gen_wstrb = '0;
    case (gen_mode)
      2'd1: begin
        gen_k     = K_W'(gen_n >> 1);
        gen_rw    = ~gen_n[0];
        gen_wdata = {8'hA5, 8'h5A, 8'hC3, gen_n};
        gen_wstrb = STRB_W'(1);
      end
      2'd2: begin
        gen_k     = gen_lfsr[K_W-1:0];
        gen_rw    = gen_lfsr[15];
        gen_wdata = {gen_lfsr, ~gen_lfsr};
        gen_wstrb = (gen_lfsr[11:8] == 4'd0) ? 4'b1111 : gen_lfsr[11:8];
      end
      default: gen_k = K_W'(gen_n);
    endcase
    gen_tag  = gen_base[ADDR_W-1:TAG_LSB] + TAG_W'(gen_k);
    gen_addr = {gen_tag, gen_base[TAG_LSB-1:0]};
  end

`ifdef CPU_TGEN_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    base_d      = base_q;
    lfsr_d      = lfsr_q;
    op_count_d  = op_count_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    req_valid_d = req_valid_q;
    req_rw_d    = req_rw_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    cur_k_d     = cur_k_q;
    shadow_d    = shadow_q;
    load_req    = 1'b0;
`ifdef CPU_TGEN_WATCHDOG_EN
    wd_d        = wd_q;
    timeout_d   = timeout_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          mode_d      = mode;
          base_d      = base_addr;
          lfsr_d      = LFSR_SEED;
          op_count_d  = '0;
          err_count_d = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
          for (int k = 0; k < NUM_TAGS; k++) begin
            shadow_d[k] = {PAT_STEP * 16'(k + 1), 16'(base_addr[OFF_W-1:2])};
          end
`ifdef CPU_TGEN_WATCHDOG_EN
          timeout_d   = 1'b0;
`endif
          load_req    = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (cpu_req_ready) begin
          req_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
          if (req_rw_q) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (req_wstrb_q[b]) shadow_d[cur_k_q][8*b +: 8] = req_wdata_q[8*b +: 8];
            end
          end
`ifdef CPU_TGEN_WATCHDOG_EN
          wd_d        = '0;
`endif
          state_d     = StWait;
        end
      end
      StWait: begin
        if (cpu_resp_valid) begin
          if (!req_rw_q && (cpu_rdata != shadow_q[cur_k_q])) begin
            if (err_count_q == 8'd0) first_err_d = req_addr_q;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end
          if (op_count_q == 8'(NUM_OPS)) begin
            pass_d  = (err_count_d == 8'd0);
            state_d = StDone;
          end else begin
            load_req = 1'b1;
            state_d  = StIssue;
          end
        end
`ifdef CPU_TGEN_WATCHDOG_EN
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = StDone;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
    if (load_req) begin
      req_valid_d = 1'b1;
      req_rw_d    = gen_rw;
      req_addr_d  = gen_addr;
      req_wdata_d = gen_wdata;
      req_wstrb_d = gen_wstrb;
      cur_k_d     = gen_k;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      base_q      <= '0;
      lfsr_q      <= '0;
      op_count_q  <= '0;
      err_count_q <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_rw_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      cur_k_q     <= '0;
      for (int k = 0; k < NUM_TAGS; k++) shadow_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      lfsr_q      <= lfsr_d;
      op_count_q  <= op_count_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
      req_valid_q <= req_valid_d;
      req_rw_q    <= req_rw_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      cur_k_q     <= cur_k_d;
      shadow_q    <= shadow_d;
    end
  end

  assign busy           = (state_q == StIssue) || (state_q == StWait);
  assign done           = (state_q == StDone);
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;
  assign op_count       = op_count_q;
  assign cpu_req_valid  = req_valid_q;
  assign cpu_req_rw     = req_rw_q;
  assign cpu_addr       = req_addr_q;
  assign cpu_wdata      = req_wdata_q;
  assign cpu_wstrb      = req_wstrb_q;

endmodule

// File: tb/tb_cpu_traffic_gen.sv
// Self-checking bench for cpu_traffic_gen: memory-backed responder plus a request-sequence model.
module tb_cpu_traffic_gen;

  localparam int NT   = 4;
  localparam int NOPS = 16;
  localparam int MAXC = 5000;

  logic        clk, rst_n, start;
  logic [1:0]  mode;
  logic [31:0] base_addr;
  logic        busy, done, pass, timeout;
  logic [7:0]  err_count, op_count;
  logic [31:0] first_err_addr;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_rw;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_resp_valid;

  cpu_traffic_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
    .first_err_addr(first_err_addr), .op_count(op_count),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_rw(cpu_req_rw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, errors;
  // Expected request stream and responder behaviour knobs
  logic [31:0] exp_addr  [256];
  logic        exp_rw    [256];
  logic [31:0] exp_wdata [256];
  logic [3:0]  exp_wstrb [256];
  logic [31:0] resp_data [256];
  logic [31:0] mem [logic [31:0]];
  int          resp_op, ready_delay, corrupt_op, drop_op;
  bit          spurious;
  time         acc_time;

  function automatic logic [31:0] addr_of(input logic [31:0] base, input int k);
    return (((base >> 8) + 32'(k)) << 8) | (base & 32'hFF);
  endfunction

  task automatic build_model(input logic [1:0] m, input logic [31:0] base);
    logic [15:0] lf;
    int k;
    lf = 16'hACE1;
    mem.delete();
    for (int t = 0; t < NT; t++)
      mem[addr_of(base, t)] = {16'(32'h1111 * (t + 1)), 16'((base >> 2) & 7)};
    for (int n = 0; n < NOPS; n++) begin
      exp_wdata[n] = 32'h0;
      exp_wstrb[n] = 4'h0;
      if (m == 2'd1) begin
        k = (n / 2) % NT;
        exp_rw[n] = (n % 2 == 0);
        exp_wdata[n] = 32'hA55AC300 + 32'(n);
        exp_wstrb[n] = 4'b0001;
      end else if (m == 2'd2) begin
        k = int'(lf) % NT;
        exp_rw[n] = lf[15];
        exp_wdata[n] = {lf, ~lf};
        exp_wstrb[n] = 4'((lf >> 8) & 16'hF);
        if (exp_wstrb[n] == 4'h0) exp_wstrb[n] = 4'hF;
        lf = {lf[14:0], ^(lf & 16'hB400)};
      end else begin
        k = n % NT;
        exp_rw[n] = 1'b0;
      end
      exp_addr[n] = addr_of(base, k);
    end
  endtask

  // Responder: optional ready stall, checks each accepted request, answers from memory model.
  initial begin : responder
    logic [31:0] a0, w0, rd, tmp;
    logic [3:0]  s0;
    logic        r0;
    int          n;
    cpu_req_ready = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_rdata = 32'h0;
    forever begin
      @(negedge clk);
      cpu_req_ready = 1'b0;
      cpu_resp_valid = 1'b0;
      if (rst_n === 1'b1 && cpu_req_valid === 1'b1) begin
        a0 = cpu_addr; r0 = cpu_req_rw; w0 = cpu_wdata; s0 = cpu_wstrb;
        for (int i = 0; i < ready_delay; i++) begin
          cpu_resp_valid = spurious && (i == 0);
          cpu_rdata = $urandom;
          @(negedge clk);
          cpu_resp_valid = 1'b0;
          checks++;
          if (cpu_req_valid !== 1'b1 || cpu_addr !== a0 || cpu_req_rw !== r0 ||
              cpu_wdata !== w0 || cpu_wstrb !== s0) begin
            errors++;
            $display("FAIL hold_stable: valid=%b addr=%h rw=%b wdata=%h wstrb=%b, required 1 %h %b %h %b",
                     cpu_req_valid, cpu_addr, cpu_req_rw, cpu_wdata, cpu_wstrb, a0, r0, w0, s0);
          end
        end
        cpu_req_ready = 1'b1;
        @(posedge clk);
        acc_time = $time;
        @(negedge clk);
        cpu_req_ready = 1'b0;
        n = resp_op;
        resp_op++;
        checks++;
        if (n >= NOPS || r0 !== exp_rw[n] || a0 !== exp_addr[n] ||
            (r0 && (w0 !== exp_wdata[n] || s0 !== exp_wstrb[n]))) begin
          errors++;
          $display("FAIL req_%0d: rw=%b addr=%h wdata=%h wstrb=%b, required rw=%b addr=%h wdata=%h wstrb=%b",
                   n, r0, a0, w0, s0, exp_rw[n % 256], exp_addr[n % 256], exp_wdata[n % 256],
                   exp_wstrb[n % 256]);
        end
        if (n < NOPS) begin
          if (r0) begin
            tmp = mem.exists(a0) ? mem[a0] : 32'h0;
            for (int b = 0; b < 4; b++) if (s0[b]) tmp[8*b +: 8] = w0[8*b +: 8];
            mem[a0] = tmp;
            cpu_rdata = $urandom;
          end else begin
            rd = mem.exists(a0) ? mem[a0] : 32'h0;
            if (n == corrupt_op) rd = rd ^ 32'h1;
            cpu_rdata = rd;
            resp_data[n] = rd;
          end
          cpu_resp_valid = (n != drop_op);
        end
      end
    end
  end

  task automatic start_run(input logic [1:0] m, input logic [31:0] base,
                           output logic v1, output logic b1);
    build_model(m, base);
    resp_op = 0;
    @(negedge clk);
    mode = m;
    base_addr = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    v1 = cpu_req_valid;
    b1 = busy;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < MAXC) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic set_knobs(input int rd, input bit sp, input int co, input int dr);
    ready_delay = rd; spurious = sp; corrupt_op = co; drop_op = dr;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu_req_valid, busy, done, pass, timeout} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: valid/busy/done/pass/timeout=%b, required 00000",
               {cpu_req_valid, busy, done, pass, timeout});
    end
    checks++;
    if (err_count !== 8'h0 || op_count !== 8'h0 || first_err_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_counts: err=%h op=%h first=%h, required 0 0 0",
               err_count, op_count, first_err_addr);
    end
    checks++;
    if (cpu_req_rw !== 1'b0 || cpu_addr !== 32'h0 || cpu_wdata !== 32'h0 || cpu_wstrb !== 4'h0) begin
      errors++;
      $display("FAIL reset_fields: rw=%b addr=%h wdata=%h wstrb=%b, required all zero",
               cpu_req_rw, cpu_addr, cpu_wdata, cpu_wstrb);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cpu_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b valid=%b, required 0 0 0",
               busy, done, cpu_req_valid);
    end
  endtask

  task automatic test_mode0;
    logic v1, b1;
    int cyc;
    set_knobs(0, 0, -1, -1);
    start_run(2'd0, 32'h44, v1, b1);
    checks++;
    if (v1 !== 1'b1 || b1 !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: valid=%b busy=%b, required 1 1", v1, b1);
    end
    wait_done(cyc);
    checks++;
    if (cyc >= MAXC) begin
      errors++;
      $display("FAIL mode0_done: done=%b after %0d cycles, required 1", done, cyc);
    end
    checks++;
    if (op_count !== 8'd16 || pass !== 1'b1 || err_count !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mode0_result: op=%0d pass=%b err=%0d busy=%b, required 16 1 0 0",
               op_count, pass, err_count, busy);
    end
  endtask

  task automatic test_corrupt;
    logic v1, b1;
    int cyc;
    set_knobs(0, 0, 2, -1);
    start_run(2'd0, 32'h44, v1, b1);
    wait_done(cyc);
    checks++;
    if (err_count !== 8'd1 || first_err_addr !== 32'h244 || pass !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL corrupt: err=%0d first=%h pass=%b done=%b, required 1 00000244 0 1",
               err_count, first_err_addr, pass, done);
    end
  endtask

  task automatic test_mode1;
    logic v1, b1;
    int cyc;
    set_knobs(0, 0, -1, -1);
    start_run(2'd1, 32'h44, v1, b1);
    wait_done(cyc);
    checks++;
    if (pass !== 1'b1 || err_count !== 8'd0 || op_count !== 8'd16) begin
      errors++;
      $display("FAIL mode1_result: pass=%b err=%0d op=%0d, required 1 0 16", pass, err_count, op_count);
    end
    checks++;
    if (resp_data[1] !== 32'h11110000 || resp_data[3] !== 32'h22220002) begin
      errors++;
      $display("FAIL mode1_readback: op1=%h op3=%h, required 11110000 22220002",
               resp_data[1], resp_data[3]);
    end
  endtask

  task automatic test_mode2;
    logic v1, b1;
    int cyc;
    set_knobs(7, 1, -1, -1);
    start_run(2'd2, 32'h44, v1, b1);
    repeat (30) @(negedge clk);
    start = 1'b1;  // must be ignored mid-run
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc >= MAXC || pass !== 1'b1 || err_count !== 8'd0 || op_count !== 8'd16 || resp_op != 16) begin
      errors++;
      $display("FAIL mode2_result: cyc=%0d pass=%b err=%0d op=%0d accepted=%0d, required pass 1 0 16 16",
               cyc, pass, err_count, op_count, resp_op);
    end
  endtask

`ifdef CPU_TGEN_WATCHDOG_EN
  task automatic test_watchdog;
    logic v1, b1;
    int c;
    time t0;
    set_knobs(0, 0, -1, 5);
    start_run(2'd0, 32'h44, v1, b1);
    c = 0;
    while (resp_op < 6 && c < 500) begin
      @(negedge clk);
      c++;
    end
    t0 = acc_time;
    c = 0;
    while (timeout !== 1'b1 && c < 3000) begin
      @(posedge clk);
      #1;
      c++;
    end
    checks++;
    if ((($time - 1) - t0) / 10 != 1024) begin
      errors++;
      $display("FAIL wd_latency: %0d cycles in wait, required 1024", (($time - 1) - t0) / 10);
    end
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || op_count !== 8'd6 || cpu_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL wd_result: done=%b pass=%b op=%0d valid=%b, required 1 0 6 0",
               done, pass, op_count, cpu_req_valid);
    end
  endtask
`endif

  task automatic test_reset_mid_run;
    logic v1, b1;
    int c;
    set_knobs(1, 0, -1, 3);
    start_run(2'd0, 32'h44, v1, b1);
    c = 0;
    while (resp_op < 4 && c < 500) begin
      @(negedge clk);
      c++;
    end
    repeat (20) @(negedge clk);
    checks++;
    if (c >= 500 || busy !== 1'b1 || timeout !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL wait_hold: reached=%0d busy=%b timeout=%b done=%b, required busy 1 0 0",
               c < 500, busy, timeout, done);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_req_valid, busy, done, pass, timeout} !== 5'b0 || op_count !== 8'h0 ||
        err_count !== 8'h0 || cpu_addr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: flags=%b op=%0d err=%0d addr=%h, required all zero",
               {cpu_req_valid, busy, done, pass, timeout}, op_count, err_count, cpu_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_knobs(1, 0, -1, -1);
    start_run(2'd0, 32'h44, v1, b1);
    wait_done(c);
    checks++;
    if (c >= MAXC || pass !== 1'b1 || op_count !== 8'd16) begin
      errors++;
      $display("FAIL rerun_after_reset: cyc=%0d pass=%b op=%0d, required pass 1 16", c, pass, op_count);
    end
  endtask

  task automatic test_random;
    logic v1, b1;
    logic [1:0] m;
    logic [31:0] base;
    int cyc;
    for (int it = 0; it < 4; it++) begin
      m = 2'($urandom_range(0, 3));
      base = $urandom;
      set_knobs(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, -1);
      start_run(m, base, v1, b1);
      wait_done(cyc);
      checks++;
      if (cyc >= MAXC || pass !== 1'b1 || err_count !== 8'd0 || op_count !== 8'd16) begin
        errors++;
        $display("FAIL random_%0d: mode=%0d base=%h pass=%b err=%0d op=%0d, required pass 1 0 16",
                 it, m, base, pass, err_count, op_count);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    mode = 2'd0;
    base_addr = 32'h0;
    set_knobs(0, 0, -1, -1);
    resp_op = 0;
    acc_time = 0;
    test_reset();
    test_mode0();
    test_corrupt();
    test_mode1();
    test_mode2();
`ifdef CPU_TGEN_WATCHDOG_EN
    test_watchdog();
`endif
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
